imem_boot_loader: RTL and testbench

- Upstream stage of the pipelined CPU: streams a program into instruction memory over a valid/ready word interface.
- Appends the all-ones halt word, holds the CPU in reset until loading is complete, then releases it.
- Counts CPU cycles from reset release until end_program and freezes the count.
- Replaces direct hierarchical pokes into instruction memory with a synthesizable load path.

---
 rtl/imem_boot_loader.sv | 178 +++++++++++++++++
 tb/tb_imem_boot_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Streams a program into instruction memory over a valid/ready word
//   interface. It appends HALT_WORD after the last program word and holds
//   the CPU in reset until SETTLE cycles after that write. It then releases
//   the CPU and counts its cycles until end_program, after which the count
//   is frozen.
//
// Ports
//   clk          system clock, all state on the rising edge
//   reset        asynchronous active-low reset
//   in_valid     program word present on in_data
//   in_data      program word
//   in_last      in_data is the final program word
//   in_ready     loader accepts a word this cycle (registered)
//   imem_we      instruction-memory write strobe
//   imem_addr    instruction-memory word address
//   imem_wdata   instruction-memory write data
//   cpu_reset    active-high reset to the CPU
//   end_program  CPU halt indication
//   word_count   program words accepted, halt word excluded
//   cycle_count  CPU cycles from reset release to end_program (saturating)
//   overflow     program hit the last usable slot without in_last; sticky
//   done         end_program observed; sticky
module imem_boot_loader #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
  parameter int unsigned SETTLE     = 4,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [31:0]           in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  input  logic                  end_program,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic                  overflow,
  output logic                  done
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  // The last slot is reserved for the halt word, so a program word
  // accepted here is the final one the memory can hold.
  localparam logic [ADDR_WIDTH-1:0] LAST_PROG_PTR = ADDR_WIDTH'(DEPTH - 2);
  localparam logic [7:0]            SETTLE_LAST   = 8'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_TERM,
    S_HOLD,
    S_RUN,
    S_DONE
  } state_e;

  state_e                state_q,     state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q,    wr_ptr_d;
  logic [7:0]            hold_cnt_q,  hold_cnt_d;
  logic                  in_ready_q,  in_ready_d;
  logic                  imem_we_q,   imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic [ADDR_WIDTH:0]   word_cnt_q,  word_cnt_d;
  logic [CNT_WIDTH-1:0]  cyc_cnt_q,   cyc_cnt_d;
  logic                  overflow_q,  overflow_d;
  logic                  done_q,      done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_LOAD;
      wr_ptr_q     <= '0;
      hold_cnt_q   <= '0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      word_cnt_q   <= '0;
      cyc_cnt_q    <= '0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      hold_cnt_q   <= hold_cnt_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      word_cnt_q   <= word_cnt_d;
      cyc_cnt_q    <= cyc_cnt_d;
      overflow_q   <= overflow_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    hold_cnt_d   = hold_cnt_q;
    in_ready_d   = in_ready_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_reset_d  = cpu_reset_q;
    word_cnt_d   = word_cnt_q;
    cyc_cnt_d    = cyc_cnt_q;
    overflow_d   = overflow_q;
    done_d       = done_q;

    case (state_q)
      S_LOAD: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = wr_ptr_q;
          imem_wdata_d = in_data;
          wr_ptr_d     = wr_ptr_q + ADDR_WIDTH'(1);
          word_cnt_d   = word_cnt_q + (ADDR_WIDTH + 1)'(1);
          if (in_last || (wr_ptr_q == LAST_PROG_PTR)) begin
            in_ready_d = 1'b0;
            state_d    = S_TERM;
            if (!in_last) begin
              overflow_d = 1'b1;
            end
          end
        end
      end
      S_TERM: begin
        // wr_ptr already points one past the last program word.
        imem_we_d    = 1'b1;
        imem_addr_d  = wr_ptr_q;
        imem_wdata_d = HALT_WORD;
        hold_cnt_d   = '0;
        state_d      = S_HOLD;
      end
      S_HOLD: begin
        if (hold_cnt_q == SETTLE_LAST) begin
          cpu_reset_d = 1'b0;
          state_d     = S_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      S_RUN: begin
        if (end_program) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (cyc_cnt_q != '1) begin
          cyc_cnt_d = cyc_cnt_q + CNT_WIDTH'(1);
        end
      end
      S_DONE: begin
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  assign in_ready    = in_ready_q;
  assign imem_we     = imem_we_q;
  assign imem_addr   = imem_addr_q;
  assign imem_wdata  = imem_wdata_q;
  assign cpu_reset   = cpu_reset_q;
  assign word_count  = word_cnt_q;
  assign cycle_count = cyc_cnt_q;
  assign overflow    = overflow_q;
  assign done        = done_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader
//   Drives two loader instances from one shared stimulus stream:
//   A (ADDR_WIDTH=6, CNT_WIDTH=32) and B (ADDR_WIDTH=3, CNT_WIDTH=4).
//   The expected outputs after every clock edge come from a timeline model.
//   The model records the edge index of each accepted word and derives
//   everything else from those edge indices arithmetically.
module tb_imem_boot_loader;

  localparam int          SETTLE = 4;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        end_program;

  logic        a_in_ready, a_imem_we, a_cpu_reset, a_overflow, a_done;
  logic [5:0]  a_imem_addr;
  logic [31:0] a_imem_wdata;
  logic [6:0]  a_word_count;
  logic [31:0] a_cycle_count;

  logic        b_in_ready, b_imem_we, b_cpu_reset, b_overflow, b_done;
  logic [2:0]  b_imem_addr;
  logic [31:0] b_imem_wdata;
  logic [3:0]  b_word_count;
  logic [3:0]  b_cycle_count;

  imem_boot_loader #(
    .ADDR_WIDTH(6), .HALT_WORD(HALT), .SETTLE(SETTLE), .CNT_WIDTH(32)
  ) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(a_in_ready), .imem_we(a_imem_we),
    .imem_addr(a_imem_addr), .imem_wdata(a_imem_wdata),
    .cpu_reset(a_cpu_reset), .end_program(end_program),
    .word_count(a_word_count), .cycle_count(a_cycle_count),
    .overflow(a_overflow), .done(a_done)
  );

  imem_boot_loader #(
    .ADDR_WIDTH(3), .HALT_WORD(HALT), .SETTLE(SETTLE), .CNT_WIDTH(4)
  ) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(b_in_ready), .imem_we(b_imem_we),
    .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata),
    .cpu_reset(b_cpu_reset), .end_program(end_program),
    .word_count(b_word_count), .cycle_count(b_cycle_count),
    .overflow(b_overflow), .done(b_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Timeline model. k counts rising edges since reset release.
  // fin  = edge at which the final program word was accepted (-1: none yet)
  // endp = edge at which end_program was seen while running (-1: none yet)
  int          k;
  int          n     [2];
  int          fin   [2];
  int          endp  [2];
  bit          ovf_m [2];
  bit          we_m  [2];
  longint      addr_m[2];
  logic [31:0] data_m[2];
  int          depth [2] = '{64, 8};
  longint      maxc  [2] = '{64'hFFFF_FFFF, 64'd15};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    k = 0;
    for (int d = 0; d < 2; d++) begin
      n[d] = 0; fin[d] = -1; endp[d] = -1; ovf_m[d] = 1'b0; we_m[d] = 1'b0;
      addr_m[d] = 0; data_m[d] = '0;
    end
  endtask

  task automatic model_edge(input logic v, input logic [31:0] dat, input logic last, input logic ep);
    for (int d = 0; d < 2; d++) begin
      we_m[d] = 1'b0;
      // in_ready is high after edge 1 until the final word is taken.
      if (k >= 2 && fin[d] < 0 && v) begin
        we_m[d] = 1'b1; addr_m[d] = n[d]; data_m[d] = dat;
        n[d]++;
        if (last || n[d] == depth[d] - 1) begin
          fin[d] = k; ovf_m[d] = !last;
        end
      end else if (fin[d] >= 0 && k == fin[d] + 1) begin
        we_m[d] = 1'b1; addr_m[d] = n[d]; data_m[d] = HALT;
      end
      if (fin[d] >= 0 && k > fin[d] + 1 + SETTLE && endp[d] < 0 && ep)
        endp[d] = k;
    end
  endtask

  task automatic check_dut(input int d, input string nm, input logic rdy, input logic we,
                           input logic [63:0] addr, input logic [31:0] wd, input logic cpur,
                           input logic [63:0] wc, input logic [63:0] cc, input logic ovf,
                           input logic dn);
    longint rel, cc_e, lastc;
    bit rdy_e, cpur_e;
    rel    = fin[d] + 1 + SETTLE;
    rdy_e  = (k >= 1) && (fin[d] < 0);
    cpur_e = !(fin[d] >= 0 && k >= rel);
    if (fin[d] < 0 || k <= rel) cc_e = 0;
    else begin
      lastc = (endp[d] >= 0) ? endp[d] - 1 : k;
      cc_e  = lastc - rel;
      if (cc_e > maxc[d]) cc_e = maxc[d];
    end
    chk($sformatf("%s_in_ready_k%0d", nm, k), 64'(rdy), 64'(rdy_e));
    chk($sformatf("%s_imem_we_k%0d", nm, k), 64'(we), 64'(we_m[d]));
    if (we_m[d]) begin
      chk($sformatf("%s_imem_addr_k%0d", nm, k), addr, 64'(addr_m[d]));
      chk($sformatf("%s_imem_wdata_k%0d", nm, k), 64'(wd), 64'(data_m[d]));
    end
    chk($sformatf("%s_cpu_reset_k%0d", nm, k), 64'(cpur), 64'(cpur_e));
    chk($sformatf("%s_word_count_k%0d", nm, k), wc, 64'(n[d]));
    chk($sformatf("%s_cycle_count_k%0d", nm, k), cc, 64'(cc_e));
    chk($sformatf("%s_overflow_k%0d", nm, k), 64'(ovf), 64'(ovf_m[d]));
    chk($sformatf("%s_done_k%0d", nm, k), 64'(dn), 64'(endp[d] >= 0));
  endtask

  task automatic tick();
    logic v, l, ep;
    logic [31:0] dat;
    v = in_valid; l = in_last; ep = end_program; dat = in_data;
    @(posedge clk);
    k++;
    model_edge(v, dat, l, ep);
    #1;
    check_dut(0, "A", a_in_ready, a_imem_we, 64'(a_imem_addr), a_imem_wdata, a_cpu_reset,
              64'(a_word_count), 64'(a_cycle_count), a_overflow, a_done);
    check_dut(1, "B", b_in_ready, b_imem_we, 64'(b_imem_addr), b_imem_wdata, b_cpu_reset,
              64'(b_word_count), 64'(b_cycle_count), b_overflow, b_done);
  endtask

  task automatic drive(input logic v, input logic [31:0] dat, input logic last);
    in_valid = v; in_data = dat; in_last = last;
    tick();
  endtask

  task automatic chk_reset_vals(input string nm, input logic rdy, input logic we,
                                input logic [63:0] addr, input logic [31:0] wd, input logic cpur,
                                input logic [63:0] wc, input logic [63:0] cc, input logic ovf,
                                input logic dn);
    chk({nm, "_rst_in_ready"}, 64'(rdy), 64'd0);
    chk({nm, "_rst_imem_we"}, 64'(we), 64'd0);
    chk({nm, "_rst_imem_addr"}, addr, 64'd0);
    chk({nm, "_rst_imem_wdata"}, 64'(wd), 64'd0);
    chk({nm, "_rst_cpu_reset"}, 64'(cpur), 64'd1);
    chk({nm, "_rst_word_count"}, wc, 64'd0);
    chk({nm, "_rst_cycle_count"}, cc, 64'd0);
    chk({nm, "_rst_overflow"}, 64'(ovf), 64'd0);
    chk({nm, "_rst_done"}, 64'(dn), 64'd0);
  endtask

  // Asserts reset between clock edges, checks the asynchronous clear before
  // the next edge, then releases on a falling edge.
  task automatic do_reset();
    #2;
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; end_program = 1'b0; in_data = '0;
    #1;
    chk_reset_vals("A", a_in_ready, a_imem_we, 64'(a_imem_addr), a_imem_wdata, a_cpu_reset,
                   64'(a_word_count), 64'(a_cycle_count), a_overflow, a_done);
    chk_reset_vals("B", b_in_ready, b_imem_we, 64'(b_imem_addr), b_imem_wdata, b_cpu_reset,
                   64'(b_word_count), 64'(b_cycle_count), b_overflow, b_done);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (cycles) tick();
  endtask

  // Two-word program; leaves both CPUs just released (k = 8).
  task automatic load_two_words();
    tick();
    drive(1'b1, 32'h00A0_0093, 1'b0);
    drive(1'b1, 32'h00B0_0113, 1'b1);
    idle(5);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; end_program = 1'b0;
    model_reset();
    do_reset();

    // Two-word program, halt word, settle, release.
    load_two_words();
    chk("S1_word_count", 64'(a_word_count), 64'd2);
    chk("S1_overflow", 64'(a_overflow), 64'd0);
    chk("S1_cpu_released", 64'(a_cpu_reset), 64'd0);

    // 37 running cycles, then end_program; B's 4-bit counter saturates.
    idle(37);
    end_program = 1'b1;
    tick();
    end_program = 1'b0;
    chk("S4_count_A", 64'(a_cycle_count), 64'd37);
    chk("S4_done_A", 64'(a_done), 64'd1);
    chk("S4_count_B_sat", 64'(b_cycle_count), 64'd15);
    repeat (20) begin
      end_program = 1'($urandom_range(0, 1));
      tick();
    end
    end_program = 1'b0;
    chk("S4_frozen_A", 64'(a_cycle_count), 64'd37);

    // Valid with gaps: 1,0,1,0,1(last), random data.
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) drive(1'(i % 2 == 0), $urandom, 1'(i == 4));
    idle(7);
    chk("S2_word_count", 64'(a_word_count), 64'd3);

    // Ten words without in_last: B stops at 7 and flags overflow.
    do_reset();
    tick();
    repeat (10) drive(1'b1, $urandom, 1'b0);
    idle(8);
    chk("S3_B_word_count", 64'(b_word_count), 64'd7);
    chk("S3_B_overflow", 64'(b_overflow), 64'd1);
    chk("S3_A_word_count", 64'(a_word_count), 64'd10);

    // Reset mid-LOAD after one word, full reload, then reset mid-RUN.
    do_reset();
    tick();
    drive(1'b1, $urandom, 1'b0);
    idle(1);
    do_reset();
    load_two_words();
    idle(10);
    chk("S5_running_count", 64'(a_cycle_count), 64'd10);
    do_reset();

    // Saturation of the 4-bit counter over 20 cycles.
    load_two_words();
    idle(20);
    chk("S6_count_A", 64'(a_cycle_count), 64'd20);
    chk("S6_count_B", 64'(b_cycle_count), 64'd15);
    end_program = 1'b1;
    tick();
    end_program = 1'b0;
    idle(3);
    chk("S6_done_B", 64'(b_done), 64'd1);
    chk("S6_final_B", 64'(b_cycle_count), 64'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
